// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and packed output stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4
);
    localparam int OUT_W = DATA_W * PACK;

    // FIFO read side
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;

    // Packed word stream toward the datapath
    logic [OUT_W-1:0]  out_data;
    logic [PACK-1:0]   out_keep;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    // The reader engine
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_keep,
        output out_valid,
        output out_last
    );

    // The FIFO plus downstream consumer
    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_keep,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a programmed byte burst from the FIFO and packs it into output words
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    fifo_burst_reader_if.master bus
);
    localparam int OUT_W  = DATA_W * PACK;
    localparam int FILL_W = $clog2(PACK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0]  remaining;
    logic [FILL_W-1:0] fill;
    logic              inflight;
    logic [OUT_W-1:0]  pack_q;

    logic [OUT_W-1:0]  out_data_q;
    logic [PACK-1:0]   out_keep_q;
    logic              out_valid_q;
    logic              out_last_q;

    logic              rd_en;
    logic              accept;
    logic              out_free;
    logic              handoff;
    logic              word_last;
    logic              start_burst;
    logic [FILL_W-1:0] fill_eff;
    logic [OUT_W-1:0]  pack_eff;
    logic [OUT_W-1:0]  word_masked;
    logic [PACK-1:0]   keep_eff;

    // Issue/landing/handoff decisions; the landing byte is folded in so a word
    // completed this cycle can be handed off without waiting an extra cycle.
    always_comb begin
        accept      = out_valid_q && bus.out_ready;
        out_free    = !out_valid_q || accept;
        start_burst = (state == S_IDLE) && start && (burst_len != '0);
        rd_en       = (state == S_READ) && !bus.fifo_empty && (remaining != '0)
                      && ((fill + FILL_W'(inflight)) < FILL_W'(PACK));

        pack_eff = pack_q;
        for (int i = 0; i < PACK; i++) begin
            if (inflight && (fill == FILL_W'(i))) begin
                pack_eff[i*DATA_W +: DATA_W] = bus.fifo_dout;
            end
        end
        fill_eff = fill + FILL_W'(inflight);

        // No pops left to issue and the one in flight lands now: nothing outstanding.
        word_last = (remaining == '0);
        handoff   = (state == S_READ) && out_free
                    && ((fill_eff == FILL_W'(PACK)) || ((fill_eff != '0) && word_last));

        keep_eff    = '0;
        word_masked = '0;
        for (int i = 0; i < PACK; i++) begin
            if (FILL_W'(i) < fill_eff) begin
                keep_eff[i]                     = 1'b1;
                word_masked[i*DATA_W +: DATA_W] = pack_eff[i*DATA_W +: DATA_W];
            end
        end
    end

    // Burst sequencing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: zero-length bursts go straight to DONE, real bursts end on last-word accept
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (burst_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (accept && out_last_q) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte counter, in-flight tracking, pack register and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining   <= '0;
            fill        <= '0;
            inflight    <= 1'b0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (start_burst) begin
                remaining <= burst_len;
                fill      <= '0;
                inflight  <= 1'b0;
                pack_q    <= '0;
            end else if (state == S_READ) begin
                inflight <= rd_en;
                if (rd_en) begin
                    remaining <= remaining - LEN_W'(1);
                end
                if (handoff) begin
                    fill   <= '0;
                    pack_q <= '0;
                end else begin
                    fill   <= fill_eff;
                    pack_q <= pack_eff;
                end
            end

            if (handoff) begin
                out_data_q  <= word_masked;
                out_keep_q  <= keep_eff;
                out_last_q  <= word_last;
                out_valid_q <= 1'b1;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_keep   = out_keep_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = (state == S_READ);
    assign done           = (state == S_DONE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader with a queue-based packing model
module tb_fifo_burst_reader;
    localparam int DATA_W = 8;
    localparam int PACK   = 4;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4096;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;

    fifo_burst_reader_if #(.DATA_W(DATA_W), .PACK(PACK)) bus ();

    fifo_burst_reader #(.DATA_W(DATA_W), .PACK(PACK), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0] stream [0:DEPTH-1];
    int    wr_cnt = 0;
    int    rd_cnt = 0;
    int    cyc = 0;
    int    exp_ptr = 0;
    int    checks = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    last_acc_cyc = -10;
    int    zero_cyc = 0;
    bit    zero_pending = 0;
    int    proto_err = 0;
    int    stab_err = 0;
    bit    stalled = 0;
    bit    rdy_rand = 0;
    logic  rdy_val = 1'b1;
    word_t held;
    word_t e_mon;
    word_t exp_q [$];
    int    r0;
    int    b0;
    int    t;

    // Byte FIFO model: bytes become visible as wr_cnt grows, dout one cycle after rd_en
    assign bus.fifo_empty = (wr_cnt == rd_cnt);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= stream[rd_cnt];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    // Downstream ready, either held or randomised
    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: split n stream bytes into PACK-byte words, first byte in the low lane
    task automatic push_expected(input int first, input int n);
        int    nwords;
        word_t e;
        nwords = (n + PACK - 1) / PACK;
        for (int w = 0; w < nwords; w++) begin
            e = '0;
            for (int k = 0; k < PACK; k++) begin
                if (w * PACK + k < n) begin
                    e.data[k*8 +: 8] = stream[first + w * PACK + k];
                    e.keep[k]        = 1'b1;
                end
            end
            e.last = (w == nwords - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: scoreboard pops, hold-stability, FIFO protocol and done timing
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (bus.fifo_rd_en && (bus.fifo_empty || !busy)) proto_err++;
            if (stalled && (!bus.out_valid || {bus.out_data, bus.out_keep, bus.out_last} != held)) stab_err++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", {bus.out_data, bus.out_keep, bus.out_last});
                end else begin
                    e_mon = exp_q.pop_front();
                    check("word", {bus.out_data, bus.out_keep, bus.out_last}, e_mon);
                end
                if (bus.out_last) last_acc_cyc = cyc;
                stalled = 0;
            end else if (bus.out_valid) begin
                stalled = 1;
                held    = {bus.out_data, bus.out_keep, bus.out_last};
            end else begin
                stalled = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, zero_pending ? zero_cyc : last_acc_cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int n);
        start     = 1'b1;
        burst_len = LEN_W'(n);
        if (n == 0) begin
            zero_pending = 1;
            zero_cyc     = cyc + 1;
        end else begin
            zero_pending = 0;
            push_expected(exp_ptr, n);
            exp_ptr += n;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit trickle);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            if (trickle && wr_cnt < DEPTH && $urandom_range(0, 1) == 1) wr_cnt++;
            tick();
            n++;
        end
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) stream[i] = 8'($urandom);
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        repeat (3) tick();
        check("reset_outputs", {bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data, busy, done}, 0);
        rst_n = 1'b1;
        tick();

        // 16 bytes ff..f0, full-rate accept
        for (int i = 0; i < 16; i++) stream[i] = 8'hff - 8'(i);
        wr_cnt += 16;
        r0 = rd_cnt;
        start_burst(16);
        wait_done(200, 0);
        check("t1_pops", rd_cnt - r0, 16);
        check("t1_empty", bus.fifo_empty, 1);
        check("t1_drained", exp_q.size(), 0);

        // 01..06: one full word then a 2-byte last word
        for (int i = 0; i < 6; i++) stream[exp_ptr + i] = 8'(i + 1);
        wr_cnt += 6;
        r0 = rd_cnt;
        start_burst(6);
        wait_done(200, 0);
        check("t2_pops", rd_cnt - r0, 6);

        // Backpressure for the first 20 cycles
        for (int i = 0; i < 16; i++) stream[exp_ptr + i] = 8'hff - 8'(i);
        wr_cnt += 16;
        r0      = rd_cnt;
        rdy_val = 1'b0;
        start_burst(16);
        repeat (19) tick();
        check("t3_pops_stalled", rd_cnt - r0, 8);
        check("t3_held_word", {bus.out_valid, bus.out_data}, {1'b1, 32'hfcfdfeff});
        rdy_val = 1'b1;
        wait_done(200, 0);
        check("t3_pops", rd_cnt - r0, 16);

        // FIFO starved mid-word: 3 bytes, then 5 more 30 cycles later
        wr_cnt += 3;
        r0 = rd_cnt;
        start_burst(8);
        repeat (30) tick();
        check("t4_pops_starved", rd_cnt - r0, 3);
        check("t4_no_word", {bus.out_valid, 32'(exp_q.size())}, {1'b0, 32'd2});
        wr_cnt += 5;
        wait_done(200, 0);
        check("t4_pops", rd_cnt - r0, 8);

        // Zero-length burst
        r0 = rd_cnt;
        start_burst(0);
        check("t5_zero_busy", busy, 0);
        wait_done(20, 0);
        check("t5_zero_pops", rd_cnt - r0, 0);

        // Start during an active burst is ignored
        wr_cnt += 8;
        r0 = rd_cnt;
        start_burst(8);
        repeat (3) tick();
        start     = 1'b1;
        burst_len = LEN_W'(3);
        tick();
        start = 1'b0;
        wait_done(200, 0);
        check("t5_second_start_pops", rd_cnt - r0, 8);
        check("t5_drained", exp_q.size(), 0);

        // Reset after 5 of 16 bytes, then a 4-byte burst picks up the next bytes
        wr_cnt += 16;
        b0 = rd_cnt;
        start_burst(16);
        t = 0;
        while (rd_cnt - b0 < 5 && t < 100) begin
            tick();
            t++;
        end
        check("t6_reached_5", rd_cnt - b0, 5);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data, busy, done}, 0);
        exp_q.delete();
        exp_ptr = b0 + 5;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6_idle_no_rd", rd_cnt - b0, 5);
        start_burst(4);
        wait_done(200, 0);
        check("t6_after_pops", rd_cnt - b0, 9);

        // Randomised bursts, ready and FIFO fill
        rdy_rand = 1;
        for (int it = 0; it < 25; it++) begin
            start_burst($urandom_range(0, 40));
            wait_done(3000, 1);
        end
        rdy_rand = 0;
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        check("fifo_protocol", proto_err, 0);
        check("hold_stability", stab_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side engine for the byte FIFO. It sits on the FIFO's rd_en/dout/empty port and drains a programmed number of bytes per burst.
- Bytes are packed into 32-bit words and presented on a valid/ready output stream toward the downstream datapath.
- It is the consumer counterpart to the FIFO's writer and owns all rd_en generation on that port.

Parameters:
- DATA_W, 8: FIFO byte width.
- PACK, 4: bytes per output word; OUT_W = DATA_W*PACK.
- LEN_W, 8: width of the burst length field, giving a maximum burst of 2^LEN_W-1 bytes.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 clears all state immediately.
- start  in  1  one-cycle pulse that begins a burst. Ignored while busy=1.
- burst_len  in  LEN_W  byte count, sampled on start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_W  FIFO read data, valid the cycle after rd_en (fixed 1-cycle latency).
- fifo_rd_en  out  1  FIFO pop request.
- out_data  out  OUT_W  packed word; the first byte popped is in bits [7:0].
- out_keep  out  PACK  byte-lane valid mask.
- out_valid  out  1  output word valid.
- out_last  out  1  marks the final word of the burst.
- out_ready  in  1  downstream accept.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the final word is accepted, or for a zero-length burst.

Behaviour:
- Reset values: fifo_rd_en, out_data, out_keep, out_valid, out_last, busy and done are all 0. The FSM returns to IDLE. Any in-flight byte is discarded.
- IDLE: on start with burst_len=0, pulse done on the next cycle and stay in IDLE; no rd_en is issued. On start with burst_len>0, load remaining=burst_len, clear fill, set busy and go to READ.
- READ, issue rule: fifo_rd_en = !fifo_empty && remaining!=0 && (fill+inflight)<PACK. Each issue decrements remaining and sets inflight for exactly one cycle.
- READ, landing: on the cycle after an issue, fifo_dout is written into lane[fill] of the pack register and fill increments.
- Word handoff: when fill reaches PACK, or fill>0 with remaining==0 and inflight==0, the pack register moves to the output register. This happens only if the output register is empty or is being accepted that cycle (out_valid && out_ready); otherwise the pack register holds.
  - On handoff: out_keep = (1<<fill)-1, unused lanes are driven 0, and out_last=1 when remaining==0 && inflight==0. fill then resets to 0.
- Throughput: sustained rate is PACK bytes per PACK+1 cycles; one bubble per word is accepted.
- Output register: once out_valid=1, out_data, out_keep and out_last are held stable until out_valid && out_ready.
- Go to DONE when the last word is accepted.
- DONE: pulse done, clear busy, return to IDLE. done is 1 for exactly one cycle.
- FIFO empty mid-burst: rd_en drops and the engine waits indefinitely with no timeout. Partial words are not flushed early.
- Backpressure: with out_ready=0, at most one word sits in the output register and one in the pack register, then rd_en stays 0. No byte is ever lost or duplicated.
- fifo_rd_en is never asserted while fifo_empty=1 in the same cycle, and never outside READ.
- A start during busy has no effect. A start coincident with the DONE cycle is also ignored.
- Reset asserted mid-burst: all state clears asynchronously. After reset release, the engine is in IDLE and no rd_en is issued until the next start.

Test Plan:
- FIFO preloaded with ff,fe,…,f0 (16 bytes), burst_len=16, out_ready=1 -> words 0xfcfdfeff, 0xf8f9fafb, 0xf4f5f6f7, 0xf0f1f2f3, each with keep=4'hf; out_last and done on the 4th word; FIFO empty afterward; exactly 16 rd_en pulses.
- FIFO holds 01..06, burst_len=6 -> 0x04030201 keep=4'hf, then 0x00000605 keep=4'h3 with last=1; done one cycle after acceptance.
- burst_len=16 with out_ready=0 for the first 20 cycles -> rd_en stops after 8 pops; first out_data holds 0xfcfdfeff stable. After release, all 4 words arrive in order with no loss.
- FIFO starts with 3 bytes, 5 more written 30 cycles later, burst_len=8 -> rd_en low while empty, no output word until byte 4; final two words correct with the last word keep=4'hf.
- start with burst_len=0 -> done pulse the next cycle, busy stays 0, no rd_en. A second start asserted during an active burst -> ignored; the burst completes with its original count.
- Reset driven low after 5 of 16 bytes -> all outputs 0 in the same cycle. After release, start burst_len=4 -> reads the next 4 FIFO bytes correctly.
